blit_rect_walker: RTL and testbench

- Upstream pixel source for the blitter's byte-combine stage.
- Accepts one rectangle-fill command at a time and walks the rectangle in raster order, one destination byte per unstalled cycle, emitting address, colour and a clip-qualified enable.
- Ends every blit with a deasserted-active flush cycle so the downstream combiner writes out its partial word.

---
 rtl/blit_rect_walker.sv | 265 ++++++++++++++++++++++++++
 tb/tb_blit_rect_walker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_rect_walker.sv
// -----------------------------------------------------------------------------
// blit_rect_walker
// Upstream pixel source for the blitter byte-combine stage. Accepts one
// rectangle-fill command at a time and walks it in raster order, one
// destination byte per unstalled cycle. Every blit ends with one unstalled
// cycle where out_active is low, so the downstream combiner flushes its
// partial word.
//
// Ports:
//   clock, resetn         rising-edge clock, asynchronous active-low reset
//   stall                 downstream stall; state and outputs hold while high
//   cmd_valid / cmd_ready command handshake (ready only in IDLE)
//   cmd_dest_addr         byte address of the rectangle top-left pixel
//   cmd_stride            bytes between rows
//   cmd_x, cmd_y          screen position of the top-left pixel (clip only)
//   cmd_width/height      rectangle size in pixels
//   cmd_colour            fill byte
//   clip_x0..clip_y1      inclusive clip window, sampled on command accept
//   out_addr/out_data     current pixel address and byte
//   out_en                pixel valid and inside the clip window
//   out_active            blit in progress; low flushes downstream
//   busy                  walker not idle
// -----------------------------------------------------------------------------
module blit_rect_walker #(
   parameter int ADDR_W   = 26,
   parameter int DIM_W    = 12,
   parameter int STRIDE_W = 16
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                stall,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_dest_addr,
   input  logic [STRIDE_W-1:0] cmd_stride,
   input  logic [DIM_W-1:0]    cmd_x,
   input  logic [DIM_W-1:0]    cmd_y,
   input  logic [DIM_W-1:0]    cmd_width,
   input  logic [DIM_W-1:0]    cmd_height,
   input  logic [7:0]          cmd_colour,
   input  logic [DIM_W-1:0]    clip_x0,
   input  logic [DIM_W-1:0]    clip_y0,
   input  logic [DIM_W-1:0]    clip_x1,
   input  logic [DIM_W-1:0]    clip_y1,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [7:0]          out_data,
   output logic                out_en,
   output logic                out_active,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t state_r, state_nxt_s;

   // Captured command and clip window
   logic [ADDR_W-1:0]   addr_r, row_addr_r;
   logic [STRIDE_W-1:0] stride_r;
   logic [DIM_W-1:0]    x_r, y_r, width_r, height_r;
   logic [7:0]          colour_r;
   logic [DIM_W-1:0]    cx0_r, cy0_r, cx1_r, cy1_r;
   logic [DIM_W-1:0]    col_r, row_r;

   // Next-cycle datapath values
   logic [ADDR_W-1:0]   addr_nxt_s, row_addr_nxt_s;
   logic [DIM_W-1:0]    col_nxt_s, row_nxt_s;

   // Next-cycle output values (registered below)
   logic [ADDR_W-1:0]   out_addr_nxt_s;
   logic [7:0]          out_data_nxt_s;
   logic                out_en_nxt_s, out_active_nxt_s, busy_nxt_s;

   logic                accept_s, last_col_s, last_s, advance_s;

   // Coordinates are summed one bit wider than the fields so they never wrap
   // back into the clip window.
   function automatic logic in_clip(
      input logic [DIM_W-1:0] base_x, input logic [DIM_W-1:0] off_x,
      input logic [DIM_W-1:0] base_y, input logic [DIM_W-1:0] off_y,
      input logic [DIM_W-1:0] x0, input logic [DIM_W-1:0] y0,
      input logic [DIM_W-1:0] x1, input logic [DIM_W-1:0] y1);
      logic [DIM_W:0] px;
      logic [DIM_W:0] py;
      px = {1'b0, base_x} + {1'b0, off_x};
      py = {1'b0, base_y} + {1'b0, off_y};
      return (px >= {1'b0, x0}) && (px <= {1'b0, x1}) &&
             (py >= {1'b0, y0}) && (py <= {1'b0, y1});
   endfunction

   assign cmd_ready  = (state_r == ST_IDLE);
   assign accept_s   = (state_r == ST_IDLE) && cmd_valid;
   assign last_col_s = (col_r == (width_r - DIM_W'(1)));
   assign last_s     = last_col_s && (row_r == (height_r - DIM_W'(1)));
   assign advance_s  = (state_r == ST_RUN) && !stall && !last_s;

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; zero-sized commands are consumed without leaving IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && (cmd_width != '0) && (cmd_height != '0)) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!stall && last_s) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (!stall) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Raster walk: next column/row counters and addresses
   always_comb begin
      col_nxt_s      = col_r;
      row_nxt_s      = row_r;
      addr_nxt_s     = addr_r;
      row_addr_nxt_s = row_addr_r;
      if (accept_s) begin
         col_nxt_s      = '0;
         row_nxt_s      = '0;
         addr_nxt_s     = cmd_dest_addr;
         row_addr_nxt_s = cmd_dest_addr;
      end else if (advance_s) begin
         if (!last_col_s) begin
            col_nxt_s  = col_r + DIM_W'(1);
            addr_nxt_s = addr_r + ADDR_W'(1);
         end else begin
            col_nxt_s      = '0;
            row_nxt_s      = row_r + DIM_W'(1);
            row_addr_nxt_s = row_addr_r + ADDR_W'(stride_r);
            addr_nxt_s     = row_addr_r + ADDR_W'(stride_r);
         end
      end else begin
         col_nxt_s      = col_r;
         row_nxt_s      = row_r;
         addr_nxt_s     = addr_r;
         row_addr_nxt_s = row_addr_r;
      end
   end

   // Output values for the pixel presented after the next edge
   always_comb begin
      out_addr_nxt_s   = '0;
      out_data_nxt_s   = 8'h00;
      out_en_nxt_s     = 1'b0;
      out_active_nxt_s = 1'b0;
      busy_nxt_s       = (state_nxt_s != ST_IDLE);
      case (state_nxt_s)
         ST_RUN: begin
            out_addr_nxt_s   = addr_nxt_s;
            out_active_nxt_s = 1'b1;
            // On accept the captured registers are not loaded yet
            if (accept_s) begin
               out_data_nxt_s = cmd_colour;
               out_en_nxt_s   = in_clip(cmd_x, col_nxt_s, cmd_y, row_nxt_s,
                                        clip_x0, clip_y0, clip_x1, clip_y1);
            end else begin
               out_data_nxt_s = colour_r;
               out_en_nxt_s   = in_clip(x_r, col_nxt_s, y_r, row_nxt_s,
                                        cx0_r, cy0_r, cx1_r, cy1_r);
            end
         end
         ST_IDLE, ST_FLUSH: begin
            out_addr_nxt_s   = '0;
            out_data_nxt_s   = 8'h00;
            out_en_nxt_s     = 1'b0;
            out_active_nxt_s = 1'b0;
         end
         default: begin
            out_addr_nxt_s   = '0;
            out_data_nxt_s   = 8'h00;
            out_en_nxt_s     = 1'b0;
            out_active_nxt_s = 1'b0;
         end
      endcase
   end

   // Walk counters and addresses
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         col_r      <= '0;
         row_r      <= '0;
         addr_r     <= '0;
         row_addr_r <= '0;
      end else begin
         col_r      <= col_nxt_s;
         row_r      <= row_nxt_s;
         addr_r     <= addr_nxt_s;
         row_addr_r <= row_addr_nxt_s;
      end
   end

   // Command and clip window capture on accept
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stride_r <= '0;
         x_r      <= '0;
         y_r      <= '0;
         width_r  <= '0;
         height_r <= '0;
         colour_r <= 8'h00;
         cx0_r    <= '0;
         cy0_r    <= '0;
         cx1_r    <= '0;
         cy1_r    <= '0;
      end else if (accept_s) begin
         stride_r <= cmd_stride;
         x_r      <= cmd_x;
         y_r      <= cmd_y;
         width_r  <= cmd_width;
         height_r <= cmd_height;
         colour_r <= cmd_colour;
         cx0_r    <= clip_x0;
         cy0_r    <= clip_y0;
         cx1_r    <= clip_x1;
         cy1_r    <= clip_y1;
      end
   end

   // Registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_addr   <= '0;
         out_data   <= 8'h00;
         out_en     <= 1'b0;
         out_active <= 1'b0;
         busy       <= 1'b0;
      end else begin
         out_addr   <= out_addr_nxt_s;
         out_data   <= out_data_nxt_s;
         out_en     <= out_en_nxt_s;
         out_active <= out_active_nxt_s;
         busy       <= busy_nxt_s;
      end
   end

endmodule

// File: tb/tb_blit_rect_walker.sv
// -----------------------------------------------------------------------------
// tb_blit_rect_walker
// Self-checking bench for blit_rect_walker. Expected pixels ({en,data,addr})
// are pushed to a queue when a command is driven and popped whenever the DUT
// presents an active pixel on an unstalled cycle.
// -----------------------------------------------------------------------------
module tb_blit_rect_walker;

   localparam int ADDR_W   = 26;
   localparam int DIM_W    = 12;
   localparam int STRIDE_W = 16;
   localparam logic [34:0] SB_EMPTY = 35'h7_FFFF_FFFF;

   logic                clock = 1'b0;
   logic                resetn;
   logic                stall;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [ADDR_W-1:0]   cmd_dest_addr;
   logic [STRIDE_W-1:0] cmd_stride;
   logic [DIM_W-1:0]    cmd_x, cmd_y, cmd_width, cmd_height;
   logic [7:0]          cmd_colour;
   logic [DIM_W-1:0]    clip_x0, clip_y0, clip_x1, clip_y1;
   logic [ADDR_W-1:0]   out_addr;
   logic [7:0]          out_data;
   logic                out_en, out_active, busy;

   logic [34:0] sb_q[$];
   logic [34:0] mon_exp;
   int n_cmp  = 0;
   int n_err  = 0;
   int en_cnt = 0;
   int act_n, fl_n, waited;

   blit_rect_walker #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .STRIDE_W(STRIDE_W)) dut (
      .clock(clock), .resetn(resetn), .stall(stall),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dest_addr(cmd_dest_addr), .cmd_stride(cmd_stride),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_width(cmd_width), .cmd_height(cmd_height),
      .cmd_colour(cmd_colour),
      .clip_x0(clip_x0), .clip_y0(clip_y0), .clip_x1(clip_x1), .clip_y1(clip_y1),
      .out_addr(out_addr), .out_data(out_data), .out_en(out_en),
      .out_active(out_active), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_clip(input int x0, input int y0, input int x1, input int y1);
      clip_x0 = DIM_W'(x0);
      clip_y0 = DIM_W'(y0);
      clip_x1 = DIM_W'(x1);
      clip_y1 = DIM_W'(y1);
   endtask

   // Reference model: raster order, modulo address, inclusive clip window
   task automatic push_blit(input int dest, input int stride, input int x, input int y,
                            input int w, input int h, input logic [7:0] colour);
      logic [ADDR_W-1:0] a;
      logic              en;
      int px, py;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            a  = ADDR_W'(dest + r * stride + c);
            px = x + c;
            py = y + r;
            en = (px >= int'(clip_x0)) && (px <= int'(clip_x1)) &&
                 (py >= int'(clip_y0)) && (py <= int'(clip_y1));
            sb_q.push_back({en, colour, a});
         end
      end
   endtask

   task automatic set_cmd(input int dest, input int stride, input int x, input int y,
                          input int w, input int h, input logic [7:0] colour);
      cmd_dest_addr = ADDR_W'(dest);
      cmd_stride    = STRIDE_W'(stride);
      cmd_x         = DIM_W'(x);
      cmd_y         = DIM_W'(y);
      cmd_width     = DIM_W'(w);
      cmd_height    = DIM_W'(h);
      cmd_colour    = colour;
      cmd_valid     = 1'b1;
      push_blit(dest, stride, x, y, w, h, colour);
   endtask

   // Returns with the accept edge just passed; n = idle cycles waited first
   task automatic wait_accept(output int n);
      bit done;
      done = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         if (cmd_ready) begin
            tick;
            done = 1'b1;
         end else begin
            tick;
            n++;
         end
      end
      cmd_valid = 1'b0;
      if (!done) check_val("accept_timeout", cmd_ready, 1);
   endtask

   task automatic issue(input int dest, input int stride, input int x, input int y,
                        input int w, input int h, input logic [7:0] colour, output int n);
      set_cmd(dest, stride, x, y, w, h, colour);
      wait_accept(n);
   endtask

   task automatic wait_idle(output int a_n, output int f_n);
      int cyc;
      a_n = 0;
      f_n = 0;
      cyc = 0;
      while (busy && cyc < 400) begin
         if (out_active) a_n++;
         else f_n++;
         tick;
         cyc++;
      end
      check_val("idle_timeout", busy, 0);
   endtask

   // Scoreboard monitor: an active pixel is consumed at the next edge if unstalled
   always @(negedge clock) begin
      if (resetn && out_active && !stall) begin
         mon_exp = (sb_q.size() > 0) ? sb_q.pop_front() : SB_EMPTY;
         check_val("pixel", {out_en, out_data, out_addr}, mon_exp);
         if (out_en) en_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b1; stall = 1'b0; cmd_valid = 1'b0;
      cmd_dest_addr = '0; cmd_stride = '0; cmd_x = '0; cmd_y = '0;
      cmd_width = '0; cmd_height = '0; cmd_colour = 8'h00;
      set_clip(0, 0, 4095, 4095);
      #1 resetn = 1'b0;
      #2;
      check_val("rst_addr", out_addr, 0);
      check_val("rst_data", out_data, 0);
      check_val("rst_en", out_en, 0);
      check_val("rst_active", out_active, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_ready", cmd_ready, 1);
      repeat (2) @(posedge clock);
      #2 resetn = 1'b1;
      tick;

      // Basic fill
      issue(32'h100, 320, 0, 0, 4, 2, 8'hA5, waited);
      check_val("t1_first_addr", out_addr, 32'h100);
      check_val("t1_first_active", out_active, 1);
      wait_idle(act_n, fl_n);
      check_val("t1_pixels", act_n, 8);
      check_val("t1_flush", fl_n, 1);
      check_val("t1_ready", cmd_ready, 1);
      check_val("t1_drain", sb_q.size(), 0);

      // Stall on pixel (2,0)
      issue(32'h100, 320, 0, 0, 4, 2, 8'hA5, waited);
      tick;
      tick;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_val("t2_hold", out_addr, 32'h102);
         tick;
      end
      stall = 1'b0;
      check_val("t2_hold_last", out_addr, 32'h102);
      wait_idle(act_n, fl_n);
      check_val("t2_rest", act_n, 6);
      check_val("t2_flush", fl_n, 1);
      check_val("t2_drain", sb_q.size(), 0);

      // Clipping
      set_clip(11, 6, 12, 6);
      en_cnt = 0;
      issue(32'h1000, 32'h80, 10, 5, 4, 3, 8'h3C, waited);
      wait_idle(act_n, fl_n);
      check_val("t3_pixels", act_n, 12);
      check_val("t3_en_count", en_cnt, 2);
      check_val("t3_drain", sb_q.size(), 0);
      set_clip(0, 0, 4095, 4095);

      // Zero-size command, then immediate next command
      issue(32'h400, 32'h10, 0, 0, 0, 7, 8'h11, waited);
      check_val("t4_busy", busy, 0);
      check_val("t4_active", out_active, 0);
      check_val("t4_ready", cmd_ready, 1);
      issue(32'h500, 32'h10, 0, 0, 2, 1, 8'h22, waited);
      check_val("t4_next_wait", waited, 0);
      wait_idle(act_n, fl_n);
      check_val("t4_next_pixels", act_n, 2);

      // Stalled flush with a queued command
      issue(32'h200, 32'h10, 0, 0, 3, 1, 8'h44, waited);
      tick;
      tick;
      tick;
      check_val("t5_flush_active", out_active, 0);
      check_val("t5_flush_busy", busy, 1);
      set_cmd(32'h600, 32'h20, 0, 0, 2, 2, 8'h66);
      stall = 1'b1;
      tick;
      check_val("t5_hold_active", out_active, 0);
      check_val("t5_hold_busy", busy, 1);
      tick;
      check_val("t5_hold_busy2", busy, 1);
      stall = 1'b0;
      tick;
      check_val("t5_idle_busy", busy, 0);
      check_val("t5_idle_ready", cmd_ready, 1);
      wait_accept(waited);
      check_val("t5_b2b_wait", waited, 0);
      check_val("t5_b_addr", out_addr, 32'h600);
      wait_idle(act_n, fl_n);
      check_val("t5_b_pixels", act_n, 4);
      check_val("t5_drain", sb_q.size(), 0);

      // Asynchronous reset mid-blit
      issue(32'h3000, 32'h100, 0, 0, 8, 2, 8'h77, waited);
      repeat (5) tick;
      check_val("t6_pix5", out_addr, 32'h3005);
      #2 resetn = 1'b0;
      #1;
      check_val("t6_rst_addr", out_addr, 0);
      check_val("t6_rst_active", out_active, 0);
      check_val("t6_rst_en", out_en, 0);
      check_val("t6_rst_data", out_data, 0);
      check_val("t6_rst_busy", busy, 0);
      sb_q.delete();
      #3 resetn = 1'b1;
      tick;
      issue(32'h5000, 32'h100, 0, 0, 8, 2, 8'h88, waited);
      check_val("t6_new_addr", out_addr, 32'h5000);
      wait_idle(act_n, fl_n);
      check_val("t6_new_pixels", act_n, 16);
      check_val("t6_new_flush", fl_n, 1);
      check_val("t6_drain", sb_q.size(), 0);

      // Address wraps modulo 2^ADDR_W
      issue(32'h3FF_FFFE, 32'h10, 0, 0, 4, 1, 8'h5A, waited);
      wait_idle(act_n, fl_n);
      check_val("t7_pixels", act_n, 4);
      check_val("t7_drain", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
